// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU datapath blocks.
package gpu_pkg;

    // Framebuffer size in 32-bit words (400x300 pixels, 4 pixels per word).
    localparam int FB_WORDS = 30000;

    // Full-word byte-enable pattern for framebuffer writes.
    localparam logic [3:0] FB_WR_ALL = 4'hF;

    // Copy engine control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with occupancy count.
// The head entry is visible on pop_data without a read strobe (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);

    // Next pointer and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/heap_to_fb_dma.sv
// Word-copy engine: streams a block of words from heap memory into the framebuffer.
// Reads are only issued when a buffer slot is reserved for the returning data, so a
// stalled framebuffer arbiter can never overflow the read-data buffer.
module heap_to_fb_dma #(
    parameter int SRC_AW     = 11,
    parameter int DST_AW     = 15,
    parameter int FB_WORDS   = gpu_pkg::FB_WORDS,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [DST_AW-1:0] dst_base,
    input  logic [DST_AW:0]   len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [SRC_AW-1:0] heap_rd_addr,
    output logic              heap_rd_en,
    input  logic [31:0]       heap_rd_data,
    output logic [DST_AW-1:0] fb_addr,
    output logic [31:0]       fb_wr_data,
    output logic [3:0]        fb_wr_en,
    input  logic              fb_wr_ready
);

    import gpu_pkg::*;

    localparam int LW  = DST_AW + 1;
    localparam int CW  = ((DST_AW > SRC_AW) ? DST_AW : SRC_AW) + 2;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int IFW = $clog2(RD_LAT + 1) + 1;

    dma_state_e        state_q, state_d;
    logic [SRC_AW-1:0] src_q, src_d;
    logic [DST_AW-1:0] dst_q, dst_d;
    logic [LW-1:0]     rd_left_q, rd_left_d;
    logic [LW-1:0]     wr_left_q, wr_left_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [IFW-1:0]    inflight_q, inflight_d;

    logic [CW-1:0]     dst_end;
    logic [CW-1:0]     src_end;
    logic              active;
    logic              rd_fire;
    logic              wr_fire;
    logic              fifo_push;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic [31:0]       fifo_head;

    // End addresses of the command, widened so the range checks cannot overflow.
    assign dst_end = CW'(dst_q) + CW'(rd_left_q);
    assign src_end = CW'(src_q) + CW'(rd_left_q);

    assign active  = (state_q == RUN) || (state_q == DRAIN);
    assign rd_fire = (state_q == RUN) && (rd_left_q != '0) &&
                     ((int'(inflight_q) + int'(fifo_count)) < FIFO_DEPTH);
    assign wr_fire = active && !fifo_empty && fb_wr_ready;

    // Read-valid pipe: data for a read lands RD_LAT cycles after it is issued.
    assign vld_d[0]  = rd_fire;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld_pipe
        assign vld_d[gi] = vld_q[gi-1];
    end
    assign fifo_push = vld_q[RD_LAT-1];

    // Reads issued whose data has not yet reached the buffer.
    always_comb begin
        inflight_d = inflight_q;
        if (rd_fire && !fifo_push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!rd_fire && fifo_push) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Control FSM: command capture, range check, read issue and write retirement.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rd_left_d = rd_left_q;
        wr_left_d = wr_left_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d     = src_base;
                    dst_d     = dst_base;
                    rd_left_d = len;
                    wr_left_d = len;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (rd_left_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if ((dst_end > CW'(FB_WORDS)) || (src_end > (CW'(1) << SRC_AW))) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (rd_fire) begin
                    src_d     = src_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                end
                if ((state_q == RUN) && (rd_left_d == '0)) begin
                    state_d = DRAIN;
                end
                if (wr_fire) begin
                    dst_d     = dst_q + 1'b1;
                    wr_left_d = wr_left_q - 1'b1;
                    if (wr_left_q == LW'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rd_left_q  <= rd_left_d;
            wr_left_q  <= wr_left_d;
            done_q     <= done_d;
            error_q    <= error_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (fifo_push),
        .push_data (heap_rd_data),
        .pop       (wr_fire),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign error        = error_q;
    assign heap_rd_addr = src_q;
    assign heap_rd_en   = rd_fire;
    assign fb_addr      = dst_q;
    assign fb_wr_en     = (active && !fifo_empty) ? FB_WR_ALL : 4'h0;
    assign fb_wr_data   = (active && !fifo_empty) ? fifo_head : 32'h0;

endmodule
